// File: rtl/fpu_issue_ctrl.sv
// Issue/retire controller for a bank of FP units: issues operands to one-hot
// selected units, captures out-of-order results and retires them in issue order.
module fpu_issue_ctrl #(
  parameter int NUM_UNITS = 10,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_UNITS-1:0]          opcode,
  input  logic [DATA_W-1:0]             x1,
  input  logic [DATA_W-1:0]             x2,
  output logic [NUM_UNITS-1:0]          unit_start,
  output logic [DATA_W-1:0]             unit_x1,
  output logic [DATA_W-1:0]             unit_x2,
  input  logic [NUM_UNITS*DATA_W-1:0]   unit_y,
  input  logic [NUM_UNITS-1:0]          unit_valid,
  input  logic [NUM_UNITS-1:0]          unit_ovf,
  input  logic [NUM_UNITS-1:0]          unit_unf,
  output logic [DATA_W-1:0]             y,
  output logic                          ovf,
  output logic                          unf,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          flag_clr,
  output logic                          sticky_ovf,
  output logic                          sticky_unf,
  output logic                          err_opcode,
  output logic                          busy
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]     fifo_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_UNITS-1:0] pending_q, pending_d;
  logic [NUM_UNITS-1:0] held_q, held_d;
  logic [NUM_UNITS-1:0] start_q;
  logic [DATA_W+1:0]    hold_q [NUM_UNITS];
  logic [DATA_W-1:0]    x1_q, x2_q;
  logic                 sticky_ovf_q, sticky_unf_q, err_q;

  logic                 onehot, full, unit_busy, accept, issue, retire, head_valid;
  logic [IDX_W-1:0]     sel_idx, head_idx;
  logic [NUM_UNITS-1:0] capture, retire_mask;
  logic [DATA_W+1:0]    head_word;

  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (opcode[k]) sel_idx = IDX_W'(k);
    end
  end

  assign onehot    = (opcode != '0) && ((opcode & (opcode - NUM_UNITS'(1))) == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign unit_busy = |((pending_q | held_q) & opcode);
  // A malformed opcode is always swallowed so it cannot wedge the requester.
  assign in_ready  = !rst && (!onehot || (!full && !unit_busy));
  assign accept    = in_valid && in_ready;
  assign issue     = accept && onehot;

  assign head_idx    = fifo_q[rd_ptr_q];
  assign head_word   = hold_q[head_idx];
  assign head_valid  = (count_q != '0) && held_q[head_idx];
  assign retire      = head_valid && out_ready;
  assign retire_mask = retire ? (NUM_UNITS'(1) << head_idx) : '0;
  assign capture     = unit_valid & pending_q;

  always_comb begin
    pending_d = (pending_q & ~capture) | (issue ? opcode : '0);
    held_d    = (held_q | capture) & ~retire_mask;
    count_d   = count_q;
    if (issue && !retire)      count_d = count_q + CNT_W'(1);
    else if (!issue && retire) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      held_q       <= '0;
      start_q      <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pending_q <= pending_d;
      held_q    <= held_d;
      count_q   <= count_d;
      start_q   <= issue ? opcode : '0;
      err_q     <= accept && !onehot;
      if (issue) begin
        x1_q     <= x1;
        x2_q     <= x2;
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (retire) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // Clear wins over a flag retiring in the same cycle.
      if (flag_clr) begin
        sticky_ovf_q <= 1'b0;
        sticky_unf_q <= 1'b0;
      end else if (retire) begin
        sticky_ovf_q <= sticky_ovf_q | head_word[DATA_W];
        sticky_unf_q <= sticky_unf_q | head_word[DATA_W+1];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (issue) fifo_q[wr_ptr_q] <= sel_idx;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (capture[k]) hold_q[k] <= {unit_unf[k], unit_ovf[k], unit_y[k*DATA_W +: DATA_W]};
    end
  end

  assign out_valid  = !rst && head_valid;
  assign y          = out_valid ? head_word[DATA_W-1:0] : '0;
  assign ovf        = out_valid && head_word[DATA_W];
  assign unf        = out_valid && head_word[DATA_W+1];
  assign unit_start = rst ? '0 : start_q;
  assign unit_x1    = x1_q;
  assign unit_x2    = x2_q;
  assign err_opcode = !rst && err_q;
  assign sticky_ovf = !rst && sticky_ovf_q;
  assign sticky_unf = !rst && sticky_unf_q;
  assign busy       = !rst && ((count_q != '0) || (|pending_q) || (|held_q));

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized scoreboard bench for fpu_issue_ctrl: unit models return results
// out of order, a monitor checks in-order retirement against issue-time expectations.
module tb_fpu_issue_ctrl;

  localparam int NU    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int NCYC  = 3000;

  logic              sys_clk = 1'b0;
  logic              rst, in_valid, in_ready, out_ready, flag_clr;
  logic [NU-1:0]     opcode, unit_start, unit_valid, unit_ovf, unit_unf;
  logic [DW-1:0]     x1, x2, unit_x1, unit_x2, y;
  logic [NU*DW-1:0]  unit_y;
  logic              ovf, unf, out_valid, sticky_ovf, sticky_unf, err_opcode, busy;

  fpu_issue_ctrl #(.NUM_UNITS(NU), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .x1(x1), .x2(x2), .unit_start(unit_start),
    .unit_x1(unit_x1), .unit_x2(unit_x2), .unit_y(unit_y),
    .unit_valid(unit_valid), .unit_ovf(unit_ovf), .unit_unf(unit_unf),
    .y(y), .ovf(ovf), .unf(unf), .out_valid(out_valid), .out_ready(out_ready),
    .flag_clr(flag_clr), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
    .err_opcode(err_opcode), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: units in flight (issued, not yet retired) in issue order.
  int unsigned       ord_q[$];
  logic [DW+1:0]     exp_q[$];
  bit                inflight [NU];
  bit                returned [NU];
  bit                stale    [NU];
  bit                real_v   [NU];
  int                cd       [NU];
  logic [DW-1:0]     plan_y   [NU];
  bit                plan_o   [NU];
  bit                plan_u   [NU];
  bit                m_sticky_o, m_sticky_u;
  logic [NU-1:0]     exp_start;
  logic [DW-1:0]     exp_x1, exp_x2;
  bit                exp_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_onehot(input logic [NU-1:0] v);
    int n = 0;
    for (int i = 0; i < NU; i++) if (v[i]) n++;
    return n == 1;
  endfunction

  function automatic int unsigned idx_of(input logic [NU-1:0] v);
    for (int i = 0; i < NU; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Stimulus: drives requests, out_ready, flag_clr and reset; predicts handshakes.
  initial begin
    bit          rst_now, quiet, exp_rdy, ok;
    int          r, a, b, phase;
    int unsigned k;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; x1 = '0; x2 = '0;
    out_ready = 1'b0; flag_clr = 1'b0;
    exp_start = '0; exp_x1 = '0; exp_x2 = '0; exp_err = 1'b0;
    m_sticky_o = 1'b0; m_sticky_u = 1'b0;
    for (int i = 0; i < NU; i++) begin
      inflight[i] = 0; returned[i] = 0; stale[i] = 0; real_v[i] = 0;
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge sys_clk);
      rst_now = (cyc < 3) || (cyc >= 1500 && cyc < 1502);
      quiet   = (cyc >= 1500 && cyc < 1512);
      rst = rst_now;
      if (rst_now) begin
        ord_q.delete(); exp_q.delete();
        for (int i = 0; i < NU; i++) begin
          inflight[i] = 0; returned[i] = 0; real_v[i] = 0; stale[i] = 1;
        end
        m_sticky_o = 1'b0; m_sticky_u = 1'b0;
        exp_start = '0; exp_err = 1'b0;
      end
      in_valid = ($urandom_range(0, 9) < 7) && !quiet;
      r = $urandom_range(0, 9);
      if (r == 0) opcode = '0;
      else if (r == 1) begin
        a = $urandom_range(0, NU-1);
        b = (a + 1 + $urandom_range(0, NU-2)) % NU;
        opcode = '0; opcode[a] = 1'b1; opcode[b] = 1'b1;
      end else begin
        opcode = '0; opcode[$urandom_range(0, NU-1)] = 1'b1;
      end
      x1 = $urandom; x2 = $urandom;
      phase = (cyc / 200) % 3;
      if (phase == 0)      out_ready = ($urandom_range(0, 9) < 8);
      else if (phase == 1) out_ready = ($urandom_range(0, 19) == 0);
      else                 out_ready = ($urandom_range(0, 1) == 1);
      flag_clr = ($urandom_range(0, 19) == 0);
      #1;
      chk("unit_start", 64'(unit_start), 64'(exp_start));
      if (exp_start != '0) begin
        chk("unit_x1", 64'(unit_x1), 64'(exp_x1));
        chk("unit_x2", 64'(unit_x2), 64'(exp_x2));
      end
      chk("err_opcode", 64'(err_opcode), 64'(exp_err));
      chk("busy", 64'(busy), 64'(ord_q.size() != 0));
      ok = is_onehot(opcode);
      k  = idx_of(opcode);
      if (rst_now)  exp_rdy = 1'b0;
      else if (!ok) exp_rdy = 1'b1;
      else          exp_rdy = (ord_q.size() < DEPTH) && !inflight[k];
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      exp_start = '0;
      exp_err   = in_valid && exp_rdy && !ok;
      if (in_valid && exp_rdy && ok) begin
        plan_y[k] = $urandom;
        plan_o[k] = ($urandom_range(0, 3) == 0);
        plan_u[k] = ($urandom_range(0, 3) == 0);
        ord_q.push_back(k);
        exp_q.push_back({plan_u[k], plan_o[k], plan_y[k]});
        inflight[k] = 1;
        exp_start = opcode; exp_x1 = x1; exp_x2 = x2;
      end
    end
    @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Unit models: each started unit answers 1..4 cycles later; idle units
  // occasionally emit stray strobes that must be ignored.
  initial begin
    unit_valid = '0; unit_ovf = '0; unit_unf = '0; unit_y = '0;
    for (int i = 0; i < NU; i++) cd[i] = 0;
    forever begin
      @(negedge sys_clk);
      #2;
      for (int i = 0; i < NU; i++) if (real_v[i]) returned[i] = 1;
      unit_valid = '0;
      for (int i = 0; i < NU; i++) begin
        real_v[i] = 0;
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) begin
            unit_valid[i] = 1'b1;
            if (stale[i]) begin
              unit_y[i*DW +: DW] = $urandom;
              unit_ovf[i] = 1'b1; unit_unf[i] = 1'b1;
            end else begin
              unit_y[i*DW +: DW] = plan_y[i];
              unit_ovf[i] = plan_o[i]; unit_unf[i] = plan_u[i];
              real_v[i] = 1;
            end
            stale[i] = 0;
          end
        end else if (unit_start[i]) begin
          cd[i] = $urandom_range(1, 4);
          stale[i] = 0;
        end else if ($urandom_range(0, 29) == 0) begin
          unit_valid[i] = 1'b1;
          unit_y[i*DW +: DW] = $urandom;
          unit_ovf[i] = 1'b1; unit_unf[i] = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT retires a result.
  initial begin
    bit            ev, ret_o, ret_u, retired;
    logic [DW+1:0] e;
    int unsigned   k;
    forever begin
      @(negedge sys_clk);
      #3;
      ev = !rst && (ord_q.size() > 0) && returned[ord_q[0]];
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("sticky_ovf", 64'(sticky_ovf), 64'(m_sticky_o));
      chk("sticky_unf", 64'(sticky_unf), 64'(m_sticky_u));
      if (rst) begin
        chk("y_in_reset", 64'(y), 64'(0));
        chk("flags_in_reset", 64'({ovf, unf}), 64'(0));
      end
      retired = 0; ret_o = 0; ret_u = 0;
      if (ev) begin
        e = exp_q[0];
        chk("y", 64'(y), 64'(e[DW-1:0]));
        chk("ovf", 64'(ovf), 64'(e[DW]));
        chk("unf", 64'(unf), 64'(e[DW+1]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          k = ord_q.pop_front();
          inflight[k] = 0; returned[k] = 0;
          retired = 1; ret_o = e[DW]; ret_u = e[DW+1];
        end
      end
      if (rst || flag_clr) begin
        m_sticky_o = 1'b0; m_sticky_u = 1'b0;
      end else if (retired) begin
        m_sticky_o = m_sticky_o | ret_o;
        m_sticky_u = m_sticky_u | ret_u;
      end
    end
  end

endmodule
